// File: rtl/spm_mem_pkg.sv
// Shared types for the SPM memory pipe: write-collision modes and
// byte-enable width helper.
package spm_mem_pkg;

    typedef enum logic [1:0] {
        WM_READ_FIRST  = 2'd0,
        WM_WRITE_FIRST = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } wmode_e;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/spm_resp_fifo.sv
// First-word-fall-through response buffer with occupancy count.
// Output data reads as zero while empty.
module spm_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        rd_d  = do_pop ? bump(rd_q) : rd_q;
        wr_d  = do_push ? bump(wr_q) : wr_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) buf_q[wr_q] <= data_i;
    end

    assign data_o  = (cnt_q != '0) ? buf_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/spm_mem_pipe.sv
// Single-port synchronous RAM behind valid/ready request/response ports,
// with byte enables, 1- or 2-cycle read latency and credit flow control.
module spm_mem_pipe
  import spm_mem_pkg::*;
#(
  parameter int     DATA_W       = 8,
  parameter int     ADDR_W       = 8,
  parameter int     DEPTH        = 1 << ADDR_W,
  parameter int     READ_LATENCY = 1,
  parameter wmode_e WRITE_MODE   = WM_READ_FIRST,
  parameter string  INIT_FILE    = "mem_init.txt"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [be_width(DATA_W)-1:0] req_be,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_write
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = READ_LATENCY + 1;
  localparam int CW    = $clog2(SLOTS + 1);
  localparam int RW    = DATA_W + 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_dw
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_W");
  end

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic                       acc, pop, in_rng;
  logic [IW-1:0]              idx;
  logic [DATA_W-1:0]          old_w, merged, rsp_d;
  logic [DATA_W-1:0]          last_rd_q, last_rd_d;
  logic [CW-1:0]              cred_q, cred_d;
  logic                       push;
  logic [RW-1:0]              push_data, fifo_data;
  logic [$clog2(SLOTS+1)-1:0] fifo_cnt;

  assign acc    = req_valid & req_ready;
  assign pop    = resp_valid & resp_ready;
  assign in_rng = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx    = IW'(req_addr);
  assign old_w  = in_rng ? mem_q[idx] : '0;

  always_comb begin
    merged = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_comb begin
    rsp_d = old_w;
    if (req_write) begin
      case (WRITE_MODE)
        WM_WRITE_FIRST: rsp_d = in_rng ? merged : '0;
        WM_NO_CHANGE:   rsp_d = last_rd_q;
        default:        rsp_d = old_w;
      endcase
    end
  end

  assign last_rd_d = (acc && !req_write) ? old_w : last_rd_q;

  always_ff @(posedge clk) begin
    if (acc && req_write && in_rng) mem_q[idx] <= merged;
  end

  always_comb begin
    cred_d = cred_q;
    case ({acc, pop})
      2'b10:   cred_d = cred_q - 1'b1;
      2'b01:   cred_d = cred_q + 1'b1;
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q    <= CW'(SLOTS);
      last_rd_q <= '0;
    end else begin
      cred_q    <= cred_d;
      last_rd_q <= last_rd_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic          s_vld_q;
    logic [RW-1:0] s_data_q;

    always_ff @(posedge clk) begin
      if (rst) s_vld_q <= 1'b0;
      else     s_vld_q <= acc;
    end

    always_ff @(posedge clk) begin
      if (acc) s_data_q <= {req_write, rsp_d};
    end

    assign push      = s_vld_q;
    assign push_data = s_data_q;
  end else begin : g_lat1
    assign push      = acc;
    assign push_data = {req_write, rsp_d};
  end

  spm_resp_fifo #(
    .DEPTH (SLOTS),
    .WIDTH (RW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  assign req_ready  = !rst && (cred_q != '0);
  assign resp_valid = (fifo_cnt != '0);
  assign {resp_write, resp_rdata} = fifo_data;

endmodule

// File: tb/tb_spm_mem_pipe.sv
// Bench for spm_mem_pipe: three configurations share one request stream,
// checked against a transaction-level memory model and a directed table.
module tb_spm_mem_pipe;
    import spm_mem_pkg::*;

    typedef struct {
        logic        w;
        logic [31:0] d;
        bit          c;
        int          t;
    } exp_t;

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld, rrdy;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, rw0, rw1, rw2;
    logic [31:0] rd0, rd1;
    logic [7:0]  rd2;
    logic [2:0]  rdy_v, rv_v, rw_v;

    assign rdy_v = {rdy2, rdy1, rdy0};
    assign rv_v  = {rv2, rv1, rv0};
    assign rw_v  = {rw2, rw1, rw0};

    always #5 clk = ~clk;

    spm_mem_pipe #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(256), .READ_LATENCY(1),
        .WRITE_MODE(WM_READ_FIRST), .INIT_FILE("")
    ) u0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy0),
        .req_write(wr), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .resp_valid(rv0), .resp_ready(rrdy[0]), .resp_rdata(rd0),
        .resp_write(rw0)
    );

    spm_mem_pipe #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .READ_LATENCY(2),
        .WRITE_MODE(WM_WRITE_FIRST), .INIT_FILE("")
    ) u1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy1),
        .req_write(wr), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .resp_valid(rv1), .resp_ready(rrdy[1]), .resp_rdata(rd1),
        .resp_write(rw1)
    );

    spm_mem_pipe #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(200), .READ_LATENCY(1),
        .WRITE_MODE(WM_NO_CHANGE), .INIT_FILE("")
    ) u2 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy2),
        .req_write(wr), .req_addr(addr), .req_wdata(wdata[7:0]),
        .req_be(be[0:0]), .resp_valid(rv2), .resp_ready(rrdy[2]),
        .resp_rdata(rd2), .resp_write(rw2)
    );

    int nchk = 0;
    int npass = 0;
    int cyc = 0;

    logic [31:0] mm [3][256];
    bit          mk [3][256];
    logic [31:0] last [3];
    bit          lastk [3];
    exp_t        eq [3][$];

    int wacc [3];
    int wpop [3];
    int wfp [3];
    int wlp [3];

    function automatic int rl(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    function automatic wmode_e md(input int i);
        case (i)
            0:       return WM_READ_FIRST;
            1:       return WM_WRITE_FIRST;
            default: return WM_NO_CHANGE;
        endcase
    endfunction

    function automatic logic [31:0] rdat(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return {24'h0, rd2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: one accepted request -> one expected response.
    task automatic macc(input int i);
        exp_t        e;
        int          nl;
        logic [31:0] old, nw;
        bit          ok, nok, inr, full;
        nl  = (i == 2) ? 1 : 4;
        inr = int'(addr) < dep(i);
        old = inr ? mm[i][addr] : 32'h0;
        ok  = inr ? mk[i][addr] : 1'b1;
        e.w = wr;
        e.t = cyc;
        if (wr) begin
            nw   = old;
            full = 1'b1;
            for (int l = 0; l < nl; l++) begin
                if (be[l]) nw[8*l +: 8] = wdata[8*l +: 8];
                else       full = 1'b0;
            end
            nok = ok | full;
            if (inr) begin
                mm[i][addr] = nw;
                mk[i][addr] = nok;
            end
            case (md(i))
                WM_READ_FIRST: begin
                    e.d = old;
                    e.c = ok;
                end
                WM_WRITE_FIRST: begin
                    e.d = inr ? nw : 32'h0;
                    e.c = inr ? nok : 1'b1;
                end
                default: begin
                    e.d = last[i];
                    e.c = lastk[i];
                end
            endcase
        end else begin
            e.d      = old;
            e.c      = ok;
            last[i]  = old;
            lastk[i] = ok;
        end
        eq[i].push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit ev;
            ev = (eq[i].size() != 0) && (eq[i][0].t + rl(i) <= cyc);
            chk($sformatf("ready[%0d]", i), {31'h0, rdy_v[i]},
                {31'h0, (!rst && (eq[i].size() < rl(i) + 1))});
            chk($sformatf("valid[%0d]", i), {31'h0, rv_v[i]}, {31'h0, ev});
            if (rv_v[i] && ev) begin
                chk($sformatf("rwrite[%0d]", i), {31'h0, rw_v[i]},
                    {31'h0, eq[i][0].w});
                if (eq[i][0].c)
                    chk($sformatf("rdata[%0d]", i), rdat(i), eq[i][0].d);
            end
            if (rv_v[i] && rrdy[i] && eq[i].size() != 0) void'(eq[i].pop_front());
            if (vld[i] && rdy_v[i]) macc(i);
            if (rst) begin
                eq[i].delete();
                last[i]  = 32'h0;
                lastk[i] = 1'b1;
            end
        end
    end

    // Runs n cycles from just after a rising edge; reads driven for nv cycles.
    task automatic window(input int n, input int nv);
        for (int i = 0; i < 3; i++) begin
            wacc[i] = 0;
            wpop[i] = 0;
            wfp[i]  = -1;
            wlp[i]  = -1;
        end
        for (int c = 0; c < n; c++) begin
            vld = (c < nv) ? 3'b111 : 3'b000;
            wr  = 1'b0;
            addr = 8'($urandom_range(0, 255));
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && rdy_v[i]) wacc[i]++;
                if (rv_v[i] && rrdy[i]) begin
                    wpop[i]++;
                    if (wfp[i] < 0) wfp[i] = cyc;
                    wlp[i] = cyc;
                end
            end
            @(posedge clk);
            #1;
        end
        vld = 3'b000;
    endtask

    task automatic apply(input vec_t v, input int k);
        logic [31:0] got [3];
        logic        gw [3];
        int          lat [3];
        logic [31:0] ex [3];
        ex[0] = v.e0;
        ex[1] = v.e1;
        ex[2] = v.e2;
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            got[i] = 32'h0;
            gw[i]  = 1'b0;
        end
        @(posedge clk);
        #1;
        wr = v.w; addr = v.a; wdata = v.d; be = v.be;
        vld = 3'b111; rrdy = 3'b111;
        @(posedge clk);
        #1;
        vld = 3'b000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rv_v[i] && lat[i] < 0) begin
                    lat[i] = c;
                    got[i] = rdat(i);
                    gw[i]  = rw_v[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("vec%0d lat[%0d]", k, i), lat[i], rl(i));
            chk($sformatf("vec%0d data[%0d]", k, i), got[i], ex[i]);
            chk($sformatf("vec%0d wr[%0d]", k, i), {31'h0, gw[i]}, {31'h0, v.w});
        end
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 32'h000000A5, 4'hF, 32'h0,        32'h000000A5, 32'h0};
        tbl[1]  = '{1'b0, 8'h10, 32'h0,        4'hF, 32'h000000A5, 32'h000000A5, 32'hA5};
        tbl[2]  = '{1'b1, 8'h03, 32'h11223344, 4'hF, 32'h0,        32'h11223344, 32'hA5};
        tbl[3]  = '{1'b1, 8'h03, 32'hAABBCCDD, 4'h5, 32'h11223344, 32'h11BB33DD, 32'hA5};
        tbl[4]  = '{1'b0, 8'h03, 32'h0,        4'h0, 32'h11BB33DD, 32'h11BB33DD, 32'hDD};
        tbl[5]  = '{1'b1, 8'hFA, 32'h000000FF, 4'hF, 32'h0,        32'h0,        32'hDD};
        tbl[6]  = '{1'b0, 8'hFA, 32'h0,        4'h0, 32'h000000FF, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 8'hC7, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0};
        tbl[8]  = '{1'b1, 8'h20, 32'h0000005A, 4'hF, 32'h0,        32'h0000005A, 32'h0};
        tbl[9]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h0000005A, 32'h0000005A, 32'h5A};
        tbl[10] = '{1'b1, 8'h21, 32'h00000077, 4'hF, 32'h0,        32'h00000077, 32'h5A};
        tbl[11] = '{1'b1, 8'h21, 32'h12345678, 4'h0, 32'h00000077, 32'h00000077, 32'h5A};
        tbl[12] = '{1'b0, 8'h21, 32'h0,        4'h0, 32'h00000077, 32'h00000077, 32'h77};

        for (int i = 0; i < 3; i++) begin
            last[i]  = 32'h0;
            lastk[i] = 1'b1;
            for (int a = 0; a < 256; a++) begin
                mm[i][a] = 32'h0;
                mk[i][a] = 1'b0;
            end
        end

        rst = 1'b1; vld = 3'b000; rrdy = 3'b000;
        wr = 1'b0; addr = 8'h0; wdata = 32'h0; be = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst valid[%0d]", i), {31'h0, rv_v[i]}, 32'h0);
            chk($sformatf("rst rdata[%0d]", i), rdat(i), 32'h0);
            chk($sformatf("rst rwrite[%0d]", i), {31'h0, rw_v[i]}, 32'h0);
        end

        // Clear every word so later reads have known contents.
        @(posedge clk);
        #1;
        rrdy = 3'b111; wr = 1'b1; be = 4'hF; wdata = 32'h0; vld = 3'b111;
        for (int a = 0; a < 256; a++) begin
            addr = 8'(a);
            @(posedge clk);
            #1;
        end
        vld = 3'b000;
        repeat (4) @(posedge clk);

        for (int k = 0; k < 13; k++) apply(tbl[k], k);

        @(posedge clk);
        #1;
        rrdy = 3'b000;
        window(6, 6);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp accepted[%0d]", i), wacc[i], rl(i) + 1);
            chk($sformatf("bp ready low[%0d]", i), {31'h0, rdy_v[i]}, 32'h0);
        end
        window(2, 0);
        rrdy = 3'b111;
        window(6, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp drained[%0d]", i), wpop[i], rl(i) + 1);
            chk($sformatf("bp back2back[%0d]", i), wlp[i] - wfp[i], rl(i));
        end

        window(12, 8);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream acc[%0d]", i), wacc[i], 8);
            chk($sformatf("stream pops[%0d]", i), wpop[i], 8);
            chk($sformatf("stream span[%0d]", i), wlp[i] - wfp[i], 7);
        end

        @(posedge clk);
        #1;
        rrdy = 3'b000; wr = 1'b0; addr = 8'h10; vld = 3'b111;
        @(posedge clk);
        #1;
        wr = 1'b1; addr = 8'h40; wdata = 32'hC3C3C3C3; be = 4'hF;
        @(posedge clk);
        #1;
        vld = 3'b000; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid-rst valid[%0d]", i), {31'h0, rv_v[i]}, 32'h0);
            chk($sformatf("mid-rst rdata[%0d]", i), rdat(i), 32'h0);
        end
        @(posedge clk);
        #1;
        rrdy = 3'b111;
        window(4, 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("no stale[%0d]", i), wpop[i], 0);
        apply('{1'b0, 8'h40, 32'h0, 4'h0, 32'hC3C3C3C3, 32'hC3C3C3C3, 32'hC3}, 13);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            vld   = 3'($urandom);
            rrdy  = 3'($urandom);
            wr    = 1'($urandom);
            addr  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(192, 207));
            wdata = $urandom;
            be    = 4'($urandom);
        end
        @(posedge clk);
        #1;
        vld = 3'b000; rrdy = 3'b111;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("final drain[%0d]", i), eq[i].size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
